// File: rtl/onehot_pkg.sv
// ---------------------------------------------------------------------------
// onehot_pkg
//   Select-vector helpers shared by the one-hot mux/demux family.
//
//   SEL_MAX_W   widest select vector the helpers accept. Narrower selects
//               are zero-extended with a size cast, for example
//               sel_vec_t'(sel).
//   sel_vec_t   select vector at maximum width.
//   sel_idx_t   binary index of the set bit in a one-hot select.
//   is_onehot   returns 1 when exactly one bit of the vector is set.
//   onehot_to_idx
//               returns the position of the set bit. The result is only
//               meaningful for a one-hot input.
// ---------------------------------------------------------------------------
package onehot_pkg;

    localparam int unsigned SEL_MAX_W = 32;
    localparam int unsigned IDX_MAX_W = 5;

    typedef logic [SEL_MAX_W-1:0] sel_vec_t;
    typedef logic [IDX_MAX_W-1:0] sel_idx_t;

    // Clearing the lowest set bit of a one-hot vector leaves zero.
    function automatic logic is_onehot(input sel_vec_t v);
        return (v != '0) && ((v & (v - sel_vec_t'(1))) == '0);
    endfunction

    // OR the positions of all set bits together. For a one-hot input this
    // is exactly the index, and the result needs no priority chain.
    function automatic sel_idx_t onehot_to_idx(input sel_vec_t v);
        sel_idx_t idx;
        idx = '0;
        for (int i = 0; i < SEL_MAX_W; i++) begin
            if (v[i]) begin
                idx = idx | sel_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// ---------------------------------------------------------------------------
// demux_slot
//   Single-entry registered output slot with a valid/ready handshake.
//
//   clk_i    clock; state changes on the rising edge
//   rst_i    synchronous, active-high reset; empties the slot and clears
//            its data
//   load_i   write data_i into the slot this cycle. The caller asserts it
//            only when the slot is empty or is being drained.
//   data_i   payload to load
//   ready_i  the consumer takes the current beat while valid_o is high
//   valid_o  the slot is occupied
//   data_o   slot payload. It holds its last value while the slot is
//            empty.
// ---------------------------------------------------------------------------
module demux_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    // A load takes priority over a drain. When both happen in the same
    // cycle the slot stays valid with the new data, so no bubble appears.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/onehot_demux.sv
// ---------------------------------------------------------------------------
// onehot_demux
//   Steers one input beat to one of N_OUT registered output slots. The
//   destination is chosen by a one-hot select. A beat whose select is not
//   one-hot is accepted and discarded. Each discard pulses err_o and
//   increments a saturating drop counter.
//
//   clk_i        clock
//   rst_i        synchronous, active-high reset
//   in_valid_i   input beat present
//   in_ready_o   input beat accepted when high together with in_valid_i.
//                It is combinational from sel_i and out_ready_i.
//   in_data_i    input payload
//   sel_i        one-hot destination channel
//   out_valid_o  per-channel slot occupied
//   out_ready_i  per-channel consumer ready
//   out_data_o   packed slot payloads; channel k is [k*DATA_W +: DATA_W]
//   err_o        one-cycle pulse after an invalid-select beat is dropped
//   drop_cnt_o   saturating count of dropped beats
// ---------------------------------------------------------------------------
module onehot_demux
    import onehot_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_W-1:0]       in_data_i,
    input  logic [N_OUT-1:0]        sel_i,
    output logic [N_OUT-1:0]        out_valid_o,
    input  logic [N_OUT-1:0]        out_ready_i,
    output logic [N_OUT*DATA_W-1:0] out_data_o,
    output logic                    err_o,
    output logic [CNT_W-1:0]        drop_cnt_o
);

    logic             sel_ok;
    logic [N_OUT-1:0] slot_free;
    logic [N_OUT-1:0] slot_load;
    logic             accept;
    logic             drop;

    assign sel_ok = is_onehot(sel_vec_t'(sel_i));

    // A slot can take a beat when it is empty or is being drained this cycle.
    assign slot_free = ~out_valid_o | out_ready_i;

    // With a one-hot select, ANDing with slot_free and OR-reducing picks out
    // the free bit of the selected slot. No binary index is needed.
    // An invalid select is always accepted so that the stream keeps moving.
    always_comb begin
        in_ready_o = 1'b1;
        if (sel_ok) begin
            in_ready_o = |(sel_i & slot_free);
        end
    end

    // Nothing is accepted while reset is held.
    assign accept    = in_valid_i && in_ready_o && !rst_i;
    assign slot_load = (accept && sel_ok) ? sel_i : '0;
    assign drop      = accept && !sel_ok;

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .load_i  (slot_load[k]),
            .data_i  (in_data_i),
            .ready_i (out_ready_i[k]),
            .valid_o (out_valid_o[k]),
            .data_o  (out_data_o[k*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o      <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            err_o <= drop;
            // After the counter saturates, err_o still pulses on each drop.
            if (drop && (drop_cnt_o != {CNT_W{1'b1}})) begin
                drop_cnt_o <= drop_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_onehot_demux.sv
module tb_onehot_demux;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [3:0]  sel;
    logic [3:0]  out_ready;

    logic        in_ready;
    logic [3:0]  out_valid;
    logic [31:0] out_data;
    logic        err;
    logic [7:0]  drop_cnt;

    logic        in_ready_s;
    logic [3:0]  out_valid_s;
    logic [31:0] out_data_s;
    logic        err_s;
    logic [1:0]  drop_cnt_s;

    int checks = 0;
    int errors = 0;

    // Reference model: the slot contents plus a count of dropped beats.
    logic [3:0]  m_valid;
    logic [7:0]  m_data [4];
    int          m_drops;
    logic        m_err;

    onehot_demux #(.DATA_W(8), .N_OUT(4), .CNT_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .sel_i       (sel),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .err_o       (err),
        .drop_cnt_o  (drop_cnt)
    );

    onehot_demux #(.DATA_W(8), .N_OUT(4), .CNT_W(2)) dut_sat (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_s),
        .in_data_i   (in_data),
        .sel_i       (sel),
        .out_valid_o (out_valid_s),
        .out_ready_i (out_ready),
        .out_data_o  (out_data_s),
        .err_o       (err_s),
        .drop_cnt_o  (drop_cnt_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then check in_ready before the edge.
    // After the edge, advance the model and check every registered output.
    task automatic step(input logic v, input logic [3:0] s, input logic [7:0] d,
                        input logic [3:0] r, input logic rs);
        int          ones;
        int          k;
        logic        exp_rdy;
        logic        acc;
        logic [31:0] exp_data;
        int          cap8;
        int          cap2;
        in_valid  = v;
        sel       = s;
        in_data   = d;
        out_ready = r;
        rst       = rs;
        #1;
        ones = $countones(s);
        k = 0;
        for (int i = 0; i < 4; i++) if (s[i]) k = i;
        exp_rdy = (ones == 1) ? (!m_valid[k] || r[k]) : 1'b1;
        if (v) begin
            check("in_ready", {63'b0, in_ready}, {63'b0, exp_rdy});
            check("in_ready_sat", {63'b0, in_ready_s}, {63'b0, exp_rdy});
        end
        @(posedge clk);
        if (rs) begin
            m_valid = '0;
            for (int j = 0; j < 4; j++) m_data[j] = 8'h00;
            m_drops = 0;
            m_err   = 1'b0;
        end else begin
            acc   = v && exp_rdy;
            m_err = acc && (ones != 1);
            for (int j = 0; j < 4; j++) begin
                if (acc && ones == 1 && j == k) begin
                    m_valid[j] = 1'b1;
                    m_data[j]  = d;
                end else if (m_valid[j] && r[j]) begin
                    m_valid[j] = 1'b0;
                end
            end
            if (m_err) m_drops++;
        end
        #1;
        exp_data = {m_data[3], m_data[2], m_data[1], m_data[0]};
        cap8 = (m_drops > 255) ? 255 : m_drops;
        cap2 = (m_drops > 3) ? 3 : m_drops;
        check("out_valid", {60'b0, out_valid}, {60'b0, m_valid});
        check("out_data", {32'b0, out_data}, {32'b0, exp_data});
        check("err", {63'b0, err}, {63'b0, m_err});
        check("drop_cnt", {56'b0, drop_cnt}, 64'(cap8));
        check("out_valid_sat", {60'b0, out_valid_s}, {60'b0, m_valid});
        check("err_sat", {63'b0, err_s}, {63'b0, m_err});
        check("drop_cnt_sat", {62'b0, drop_cnt_s}, 64'(cap2));
    endtask

    initial begin
        logic [3:0] rs_sel;
        m_valid = '0;
        for (int j = 0; j < 4; j++) m_data[j] = 8'h00;
        m_drops = 0;
        m_err   = 1'b0;
        in_valid = 1'b0; sel = '0; in_data = '0; out_ready = '0; rst = 1'b1;

        // Reset state.
        step(1'b0, 4'b0000, 8'h00, 4'b0000, 1'b1);
        check("reset_valid_const", {60'b0, out_valid}, 64'h0);

        // A single beat to channel 2.
        step(1'b1, 4'b0100, 8'hA5, 4'b0000, 1'b0);
        check("ch2_data", {56'b0, out_data[23:16]}, 64'hA5);
        check("ch2_only", {60'b0, out_valid}, 64'h4);

        // Channel 1 stalls, then drains and loads in the same cycle.
        step(1'b1, 4'b0010, 8'h11, 4'b0000, 1'b0);
        step(1'b1, 4'b0010, 8'h22, 4'b0000, 1'b0);
        check("ch1_held", {56'b0, out_data[15:8]}, 64'h11);
        step(1'b1, 4'b0010, 8'h22, 4'b0010, 1'b0);
        check("ch1_reload", {56'b0, out_data[15:8]}, 64'h22);
        step(1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0);

        // Invalid selects: zero bits set, then two bits set.
        step(1'b1, 4'b0000, 8'h33, 4'b0000, 1'b0);
        step(1'b1, 4'b0011, 8'h44, 4'b0000, 1'b0);
        check("drop_cnt_two", {56'b0, drop_cnt}, 64'd2);
        step(1'b0, 4'b0011, 8'h00, 4'b0000, 1'b0);

        // Five more drops take the CNT_W=2 counter past saturation.
        for (int i = 0; i < 5; i++) step(1'b1, 4'b1111, 8'h55, 4'b0000, 1'b0);
        check("sat_end", {62'b0, drop_cnt_s}, 64'd3);

        // Empty all slots, then send back-to-back beats to channels 0 and 3.
        step(1'b0, 4'b0000, 8'h00, 4'b1111, 1'b0);
        step(1'b1, 4'b0001, 8'hC0, 4'b1111, 1'b0);
        step(1'b1, 4'b1000, 8'hC3, 4'b1111, 1'b0);
        step(1'b1, 4'b0001, 8'hD0, 4'b1111, 1'b0);
        step(1'b1, 4'b1000, 8'hD3, 4'b1111, 1'b0);
        step(1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0);

        // Reset while slots 0 and 3 are occupied.
        step(1'b1, 4'b0001, 8'hE0, 4'b0000, 1'b0);
        step(1'b1, 4'b1000, 8'hE3, 4'b0000, 1'b0);
        step(1'b1, 4'b0100, 8'hE2, 4'b0000, 1'b1);
        check("rst_mid_data", {32'b0, out_data}, 64'h0);

        // Random traffic, with an occasional reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 7) rs_sel = 4'(1 << $urandom_range(0, 3));
            else                          rs_sel = 4'($urandom);
            step(1'($urandom), rs_sel, 8'($urandom), 4'($urandom),
                 ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
